// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM state
// constants and the sub-word extract/merge helpers.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef logic [2:0] lsu_state_t;

   localparam lsu_state_t S_IDLE  = 3'd0;
   localparam lsu_state_t S_LOAD  = 3'd1;
   localparam lsu_state_t S_ST_RD = 3'd2;
   localparam lsu_state_t S_ST_WR = 3'd3;
   localparam lsu_state_t S_RESP  = 3'd4;

   // Select the addressed byte/half of a memory word and extend it.
   function automatic logic [31:0] lsu_extract(
      input logic [31:0] word,
      input logic [1:0]  off,
      input logic [1:0]  size,
      input logic        uns
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Substitute right-aligned store data into a word at the byte offset.
   function automatic logic [31:0] lsu_merge(
      input logic [31:0] word,
      input logic [31:0] wdata,
      input logic [1:0]  off,
      input logic [1:0]  size
   );
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: begin
            case (off)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off[1]) r[31:16] = wdata[15:0];
            else        r[15:0]  = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Pure combinational sub-word extract (loads) and merge (stores).
// No state; reusable by any word-organised memory client.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] rdata,
   input  logic [31:0] merge_src,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   // Extraction and merge are independent; both evaluated every cycle.
   always_comb begin
      load_data  = lsu_extract(rdata, offset, size, is_unsigned);
      store_data = lsu_merge(merge_src, wdata, offset, size);
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready request in, valid/ready response out,
// drives a word-wide data memory. Sub-word stores use read-modify-write.
// Optional performance counters enabled by defining LSU_PERF_CNT_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_w_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_w_data,
   input  logic [DATA_W-1:0] mem_r_data
`ifdef LSU_PERF_CNT_EN
   ,
   output logic [31:0]       perf_loads,
   output logic [31:0]       perf_stores,
   output logic [31:0]       perf_errs
`endif
);

   lsu_state_t        state;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       merge_q;
   logic [31:0]       load_data;
   logic [31:0]       store_data;
   logic              req_err;
   logic              accept;
   logic              resp_fire;

   lsu_data_align u_align (
      .offset      (r_addr[1:0]),
      .size        (r_size),
      .is_unsigned (r_unsigned),
      .rdata       (mem_r_data),
      .merge_src   (merge_q),
      .wdata       (r_wdata),
      .load_data   (load_data),
      .store_data  (store_data)
   );

   // Request legality: reserved size, misalignment, address beyond memory.
   always_comb begin
      req_err = 1'b0;
      if (req_size == SZ_RSVD)                          req_err = 1'b1;
      if (req_size == SZ_HALF && req_addr[0])           req_err = 1'b1;
      if (req_size == SZ_WORD && req_addr[1:0] != 2'b0) req_err = 1'b1;
      if (req_addr[31:ADDR_W] != '0)                    req_err = 1'b1;
   end

   // Handshake and memory-side outputs decoded from the state.
   always_comb begin
      req_ready    = (state == S_IDLE);
      resp_valid   = (state == S_RESP);
      accept       = req_valid && req_ready;
      resp_fire    = resp_valid && resp_ready;
      // rst gating keeps an in-flight write from landing on the reset cycle
      mem_w_enable = (state == S_ST_WR) && !rst;
      mem_addr     = '0;
      mem_w_data   = '0;
      if (state == S_LOAD || state == S_ST_RD || state == S_ST_WR)
         mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
      if (state == S_ST_WR)
         mem_w_data = store_data;
   end

   // Main FSM with request capture and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         r_we       <= 1'b0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         merge_q    <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  r_we       <= req_we;
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_addr     <= req_addr[ADDR_W-1:0];
                  r_wdata    <= req_wdata;
                  merge_q    <= '0;
                  resp_rdata <= '0;
                  if (req_err) begin
                     resp_err <= 1'b1;
                     state    <= S_RESP;
                  end else begin
                     resp_err <= 1'b0;
                     if (!req_we)                 state <= S_LOAD;
                     else if (req_size == SZ_WORD) state <= S_ST_WR;
                     else                          state <= S_ST_RD;
                  end
               end
            end
            S_LOAD: begin
               resp_rdata <= load_data;
               state      <= S_RESP;
            end
            S_ST_RD: begin
               merge_q <= mem_r_data;
               state   <= S_ST_WR;
            end
            S_ST_WR: begin
               resp_rdata <= '0;
               state      <= S_RESP;
            end
            S_RESP: begin
               if (resp_fire) begin
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef LSU_PERF_CNT_EN
   // Count completed responses by kind; errors are counted only as errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_loads  <= '0;
         perf_stores <= '0;
         perf_errs   <= '0;
      end else if (resp_fire) begin
         if (resp_err)  perf_errs   <= perf_errs + 32'd1;
         else if (r_we) perf_stores <= perf_stores + 32'd1;
         else           perf_loads  <= perf_loads + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a behavioural word memory.
// Expected responses are queued at issue and popped when the response appears.
module tb_load_store_unit;

   localparam int ADDR_W = 14;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_w_enable;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;
`ifdef LSU_PERF_CNT_EN
   logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

   logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
   int          wr_count = 0;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          writes;
   } exp_t;
   exp_t sb[$];

   load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_w_enable (mem_w_enable),
      .mem_addr     (mem_addr),
      .mem_w_data   (mem_w_data),
      .mem_r_data   (mem_r_data)
`ifdef LSU_PERF_CNT_EN
      ,
      .perf_loads   (perf_loads),
      .perf_stores  (perf_stores),
      .perf_errs    (perf_errs)
`endif
   );

   always #5 clk = ~clk;

   assign mem_r_data = mem[mem_addr[ADDR_W-1:2]];

   // Write enable is held for the whole ST_WR cycle; capture mid-cycle.
   always @(negedge clk) begin
      if (mem_w_enable) begin
         mem[mem_addr[ADDR_W-1:2]] <= mem_w_data;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_writes, input int hold);
      exp_t e;
      int   n;
      int   wr_before;
      sb.push_back('{rdata: exp_rdata, err: exp_err, lat: exp_lat, writes: exp_writes});
      wr_before = wr_count;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      check("req_ready_idle", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = ~we; req_size = $urandom_range(0, 3);
      req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
      n = 1;
      @(negedge clk);
      while (!resp_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("resp_timeout", {31'b0, (n >= 20)}, 32'd0);
      e = sb.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      check("latency", n, e.lat);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", {31'b0, resp_valid}, 32'd1);
         check("hold_rdata", resp_rdata, e.rdata);
         check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("valid_cleared", {31'b0, resp_valid}, 32'd0);
      check("idle_after", {31'b0, req_ready}, 32'd1);
      check("write_count", wr_count - wr_before, e.writes);
   endtask

   initial begin
      for (int i = 0; i < (1 << (ADDR_W - 2)); i++) mem[i] = '0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_mem_we", {31'b0, mem_w_enable}, 32'd0);
      check("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
      check("rst_mem_wdata", mem_w_data, 32'd0);

      // word store then word load
      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
      check("mem_word_store", mem[4], 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);

      // byte store via read-modify-write
      do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFF5A, 32'h0, 1'b0, 3, 1, 0);
      check("mem_byte_store", mem[4], 32'hDE5ABEEF);

      // byte and half loads with extension
      do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 32'h0000005A, 1'b0, 2, 0, 0);
      do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 0);
      do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2, 0, 0);
      do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0, 0);
      do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000DE5A, 1'b0, 2, 0, 0);

      // half store into upper half of a different word
      mem[8] = 32'h11223344;
      do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD8765, 32'h0, 1'b0, 3, 1, 0);
      check("mem_half_store", mem[8], 32'h87653344);

      // error cases: no memory traffic, response after one cycle
      do_req(1'b0, 2'd2, 1'b0, 32'h11,   32'h0, 32'h0, 1'b1, 1, 0, 0);
      do_req(1'b1, 2'd1, 1'b0, 32'h13,   32'h1234, 32'h0, 1'b1, 1, 0, 0);
      do_req(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
      do_req(1'b0, 2'd3, 1'b0, 32'h10,   32'h0, 32'h0, 1'b1, 1, 0, 0);
      check("mem_after_errs", mem[4], 32'hDE5ABEEF);

      // response back-pressure
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE5ABEEF, 1'b0, 2, 0, 5);

      // reset during ST_RD of a byte store aborts the write
      begin
         int wr_before;
         wr_before = wr_count;
         @(negedge clk);
         req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
         req_addr = 32'h10; req_wdata = 32'hAA;
         @(posedge clk);
         #1 req_valid = 1'b0;
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         check("abort_req_ready", {31'b0, req_ready}, 32'd1);
         check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
         check("abort_mem_we", {31'b0, mem_w_enable}, 32'd0);
         check("abort_mem_addr", {18'b0, mem_addr}, 32'd0);
         repeat (3) @(negedge clk);
         check("abort_writes", wr_count - wr_before, 32'd0);
         check("abort_mem_word", mem[4], 32'hDE5ABEEF);
      end

      // unit still works after the aborted access
      do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h000000EF, 1'b0, 2, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the processor's word-addressed data memory interface.
- Accepts load/store requests from the execute stage over a valid/ready handshake and drives the memory's w_enable/addr/w_data.
- Extracts byte/halfword load data from mem_r_data, with sign- or zero-extension.
- The memory writes whole words only, so sub-word stores use a read-modify-write sequence.

Parameters:
- ADDR_W, 14, byte-address width of the data memory (word index = addr[ADDR_W-1:2]).
- DATA_W, 32, data width; fixed at 32, the parameter exists for clarity only.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1=store, 0=load.
- req_size  input  2  0=byte, 1=half, 2=word, 3=reserved.
- req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  32  load result; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or reserved-size request.
- mem_w_enable  output  1  to memory w_enable.
- mem_addr  output  ADDR_W  to memory addr.
- mem_w_data  output  32  to memory w_data.
- mem_r_data  input  32  from memory; combinational read of mem_addr.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_w_enable=0, mem_addr=0, mem_w_data=0, all request registers cleared. A reset mid-operation aborts any access; no write occurs in the cycle rst is high.
- req_ready = (state==IDLE). A request is accepted on a posedge where req_valid && req_ready. Request fields are registered at acceptance; inputs are ignored afterwards.
- Error check at acceptance:
  - size 3.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - req_addr[31:ADDR_W]!=0.
  - On any error: go directly to RESP with resp_err=1, resp_rdata=0; memory is never driven.
- mem_w_enable is high only in ST_WR. mem_addr holds the registered word-aligned address (low 2 bits 0) in LOAD/ST_RD/ST_WR, and 0 otherwise.
- States:
  - IDLE -> LOAD (load), ST_WR (word store), ST_RD (byte/half store), RESP (error).
  - LOAD: capture mem_r_data. Select the byte (addr[1:0]) or half (addr[1]), extend per req_unsigned, register into resp_rdata. -> RESP.
  - ST_RD: capture mem_r_data into merge register. -> ST_WR.
  - ST_WR: mem_w_data = merge register with req_wdata[7:0] or [15:0] substituted at the byte offset (word store: req_wdata verbatim). mem_w_enable=1 for exactly this one cycle. -> RESP.
  - RESP: resp_valid=1, outputs stable until resp_ready. On resp_valid && resp_ready -> IDLE, resp_valid=0 next cycle.
- Latency, acceptance edge T to resp_valid:
  - load / word store: T+2.
  - sub-word store: T+3.
  - error: T+1.
- No back-to-back acceptance: the minimum issue interval is latency+1 cycles.
- resp_rdata is 0 for every store.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined: adds outputs perf_loads[31:0], perf_stores[31:0], perf_errs[31:0].
  - Each increments on the response handshake of the matching kind; errors count in perf_errs only.
  - All wrap at 2^32 and clear on rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum lsu_state_t.
  - function for load extraction/extension.
  - function for store merge.
- One sub-module, lsu_data_align: pure combinational extract/merge given offset, size and unsigned flag. Reusable by a future cache.
- Pair load_store_unit with data_memory in a top-level bench.

Test Plan:
- Store word 0xDEADBEEF at 0x0010, then load word 0x0010 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at T+2.
- With 0x0010=0xDEADBEEF, store byte 0x5A at 0x0012 -> one write of 0xDE5ABEEF; load byte signed 0x0012 -> 0x0000005A; load byte signed 0x0013 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Load half signed 0x0010 -> 0xFFFFBEEF; unsigned 0x0012 -> 0x0000DE5A.
- Misaligned word load 0x0011, half store 0x0013, address 0x4000, size=3 -> resp_err=1, resp_rdata=0, mem_w_enable never asserted, resp at T+1.
- Hold resp_ready=0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0; release -> IDLE next cycle.
- Assert rst during ST_RD of a byte store -> no write occurs, all outputs reset values, memory word unchanged.
